// File: rtl/vx_tensor_warp_sequencer_pkg.sv
// Shared constants and types for the tensor-core warp sequencer: HMMA sequence
// geometry and the lock state encoding.
package vx_tensor_warp_sequencer_pkg;

    localparam int TC_NUM_STEPS      = 4;
    localparam int TC_BEATS_PER_STEP = 2;
    localparam int TC_BEATS_PER_SEQ  = TC_NUM_STEPS * TC_BEATS_PER_STEP;

    typedef enum logic {
        TC_SEQ_IDLE,
        TC_SEQ_LOCKED
    } tc_seq_state_e;

    // Step a beat must carry, given its position inside the locked sequence.
    function automatic logic [1:0] expected_step(input int unsigned beat);
        return 2'(beat / TC_BEATS_PER_STEP);
    endfunction

endpackage

// File: rtl/vx_tensor_warp_sequencer_if.sv
// Bundle of per-warp request beats and the single tensor-core execute port.
interface vx_tensor_warp_sequencer_if #(
    parameter int NUM_REQ = 4,
    parameter int DATAW   = 64
);
    localparam int WID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][1:0]       req_step;
    logic [NUM_REQ-1:0][DATAW-1:0] req_data;

    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_step;
    logic [WID_W-1:0] out_wid;
    logic [DATAW-1:0] out_data;

    // master: warp dispatch buffers plus the tensor core; slave: the sequencer
    modport master (
        output req_valid, req_step, req_data, out_ready,
        input  req_ready, out_valid, out_step, out_wid, out_data
    );

    modport slave (
        input  req_valid, req_step, req_data, out_ready,
        output req_ready, out_valid, out_step, out_wid, out_data
    );

endinterface

// File: rtl/vx_tensor_warp_sequencer_rr_arbiter.sv
// Round-robin picker over warp valids; the rotating pointer lives here and only
// moves when the caller consumes a grant.
module vx_tensor_warp_sequencer_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the requester closest to ptr_q wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vx_tensor_warp_sequencer.sv
// Shares one tensor-core execute port among warps, holding the port for a whole
// HMMA sequence so octet substep state never mixes between warps.
module vx_tensor_warp_sequencer
    import vx_tensor_warp_sequencer_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATAW         = 64,
    parameter int BEATS_PER_SEQ = TC_BEATS_PER_SEQ
) (
    input  logic                         clk,
    input  logic                         reset,
    vx_tensor_warp_sequencer_if.slave    bus,
    output logic                         busy,
    output logic                         seq_done,
    output logic                         err_step
);
    localparam int WID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BEATS_PER_SEQ);

    tc_seq_state_e    state_q, state_d;
    logic [WID_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             seq_done_q, seq_done_d;
    logic             err_step_q, err_step_d;

    logic             grant_valid;
    logic [WID_W-1:0] grant_idx;
    logic             locked;
    logic             fire;

    assign locked = (state_q == TC_SEQ_LOCKED);
    assign fire   = locked && bus.req_valid[owner_q] && bus.out_ready;

    vx_tensor_warp_sequencer_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req_valid),
        .advance     (!locked),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TC_SEQ_IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            seq_done_q <= 1'b0;
            err_step_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            seq_done_q <= seq_done_d;
            err_step_q <= err_step_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        seq_done_d = 1'b0;
        err_step_d = 1'b0;
        case (state_q)
            TC_SEQ_IDLE: begin
                if (grant_valid) begin
                    owner_d    = grant_idx;
                    beat_cnt_d = '0;
                    state_d    = TC_SEQ_LOCKED;
                end
            end
            TC_SEQ_LOCKED: begin
                // A mis-stepped beat is flagged but still forwarded and counted.
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    err_step_d = (bus.req_step[owner_q] != expected_step(32'(beat_cnt_q)));
                    if (beat_cnt_q == CNT_W'(BEATS_PER_SEQ - 1)) begin
                        beat_cnt_d = '0;
                        seq_done_d = 1'b1;
                        state_d    = TC_SEQ_IDLE;
                    end
                end
            end
            default: state_d = TC_SEQ_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_step  = '0;
        bus.out_wid   = '0;
        bus.out_data  = '0;
        if (locked) begin
            busy          = 1'b1;
            bus.out_valid = bus.req_valid[owner_q];
            bus.out_step  = bus.req_step[owner_q];
            bus.out_wid   = owner_q;
            bus.out_data  = bus.req_data[owner_q];
        end
    end

    // Only the owner ever sees ready; everyone else waits out the sequence.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = locked && (owner_q == WID_W'(gi)) && bus.out_ready;
    end

    assign seq_done = seq_done_q;
    assign err_step = err_step_q;

endmodule

// File: tb/tb_vx_tensor_warp_sequencer.sv
// Directed bench: stimulus loads per-warp beat stores and pushes expected beats
// into a ring; a negedge monitor pops and compares every forwarded beat.
module tb_vx_tensor_warp_sequencer;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam logic [15:0] STEPS_OK  = 16'hFA50; // 0,0,1,1,2,2,3,3 (beat 0 in LSBs)
    localparam logic [15:0] STEPS_BAD = 16'hFAA0; // 0,0,2,2,2,2,3,3

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy, seq_done, err_step;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vx_tensor_warp_sequencer_if #(.NUM_REQ(NR), .DATAW(DW)) bus ();

    vx_tensor_warp_sequencer #(
        .NUM_REQ(NR), .DATAW(DW), .BEATS_PER_SEQ(8)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .seq_done (seq_done),
        .err_step (err_step)
    );

    typedef struct {
        int          wid;
        logic [1:0]  step;
        logic [63:0] data;
        logic        err;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb_mem [256];
    int   sb_wr = 0;
    int   sb_rd = 0;
    int   tmo_req = 0;
    int   tmo_ack = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [1:0]  w_step [NR][64];
    logic [63:0] w_data [NR][64];
    int          w_head [NR];
    int          w_tail [NR];

    bit         tog_en = 1'b0;
    logic [3:0] tog_pat = 4'b1001;
    int         tog_idx = 0;

    // ---------------- monitor / scoreboard ----------------
    bit          pend_v = 1'b0, pend_err = 1'b0, pend_last = 1'b0;
    bit          hold_v = 1'b0;
    logic [63:0] hold_data;
    logic [1:0]  hold_wid;
    logic [3:0]  rr_exp;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_busy",      64'(busy), 64'd0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_out_data",  bus.out_data, 64'd0);
            chk("rst_out_step",  64'(bus.out_step), 64'd0);
            chk("rst_out_wid",   64'(bus.out_wid), 64'd0);
            chk("rst_seq_done",  64'(seq_done), 64'd0);
            chk("rst_err_step",  64'(err_step), 64'd0);
            pend_v = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (tmo_ack != tmo_req) begin
                n_assert++;
                n_fail++;
                $display("FAIL drain_timeout: got %0d beats outstanding expected 0", sb_wr - sb_rd);
                tmo_ack = tmo_req;
                sb_rd   = sb_wr;
            end
            if (pend_v) begin
                chk("seq_done", 64'(seq_done), 64'(pend_last));
                chk("err_step", 64'(err_step), 64'(pend_err));
                pend_v = 1'b0;
            end else begin
                chk("seq_done_quiet", 64'(seq_done), 64'd0);
                chk("err_step_quiet", 64'(err_step), 64'd0);
            end
            rr_exp = '0;
            if (busy && bus.out_ready) rr_exp = 4'b0001 << bus.out_wid;
            chk("req_ready_mask", 64'(bus.req_ready), 64'(rr_exp));
            if (hold_v && bus.out_valid) begin
                chk("stall_data", bus.out_data, hold_data);
                chk("stall_wid",  64'(bus.out_wid), 64'(hold_wid));
            end
            hold_v    = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_wid  = bus.out_wid;
            if (bus.out_valid && bus.out_ready) begin
                chk("fire_busy", 64'(busy), 64'd1);
                if (sb_rd == sb_wr) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got wid %0d data %0h expected no beat", bus.out_wid, bus.out_data);
                end else begin
                    mon_e = sb_mem[sb_rd % 256];
                    sb_rd++;
                    chk("beat_wid",  64'(bus.out_wid), 64'(mon_e.wid));
                    chk("beat_step", 64'(bus.out_step), 64'(mon_e.step));
                    chk("beat_data", bus.out_data, mon_e.data);
                    if (mon_e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
                    pend_v    = 1'b1;
                    pend_err  = mon_e.err;
                    pend_last = mon_e.last;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive();
        for (int w = 0; w < NR; w++) begin
            if (w_head[w] < w_tail[w]) begin
                bus.req_valid[w] = 1'b1;
                bus.req_step[w]  = w_step[w][w_head[w]];
                bus.req_data[w]  = w_data[w][w_head[w]];
            end else begin
                bus.req_valid[w] = 1'b0;
                bus.req_step[w]  = '0;
                bus.req_data[w]  = '0;
            end
        end
    endtask

    function automatic bit warps_pending();
        bit p = 1'b0;
        for (int w = 0; w < NR; w++) if (w_head[w] < w_tail[w]) p = 1'b1;
        return p;
    endfunction

    task automatic step_clk();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int w = 0; w < NR; w++) if (acc[w] && w_head[w] < w_tail[w]) w_head[w]++;
        if (tog_en) begin
            bus.out_ready = tog_pat[tog_idx];
            tog_idx = (tog_idx + 1) % 4;
        end
        drive();
    endtask

    // first_cyc < 0 disables the per-beat cycle check
    task automatic load_seq(input int w, input int tag, input logic [15:0] steps,
                            input logic [7:0] err_mask, input int first_cyc, input int n_exp);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) begin
            d = {16'hA5A5, 16'(tag), 16'(w), 16'(b)};
            w_step[w][w_tail[w]] = steps[2*b +: 2];
            w_data[w][w_tail[w]] = d;
            w_tail[w]++;
            if (b < n_exp) begin
                sb_mem[sb_wr % 256] = '{wid: w, step: steps[2*b +: 2], data: d, err: err_mask[b],
                                        last: (b == 7), cyc: (first_cyc < 0) ? -1 : first_cyc + b};
                sb_wr++;
            end
        end
        drive();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_rd != sb_wr || busy || warps_pending()) && n < budget) begin
            step_clk();
            n++;
        end
        if (n >= budget) begin
            tmo_req++;
            for (int w = 0; w < NR; w++) w_head[w] = w_tail[w];
            drive();
        end
        step_clk();
        step_clk();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int w = 0; w < NR; w++) begin
            w_head[w] = 0;
            w_tail[w] = 0;
        end
        tog_en = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        step_clk();
        step_clk();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.out_ready = 1'b1;
        drive();

        // 1: single warp 1, clean sequence, back-to-back fires
        do_reset();
        k = cyc;
        load_seq(1, 10, STEPS_OK, 8'h00, k + 1, 8);
        wait_drain(60);

        // 2: warps 0 and 2 together; warp 2 starts two cycles after warp 0 ends
        do_reset();
        k = cyc;
        load_seq(0, 20, STEPS_OK, 8'h00, k + 1, 8);
        load_seq(2, 21, STEPS_OK, 8'h00, k + 10, 8);
        wait_drain(80);

        // 3: warp 3 with wrong steps on beats 2 and 3
        do_reset();
        k = cyc;
        load_seq(3, 30, STEPS_BAD, 8'b0000_1100, k + 1, 8);
        wait_drain(60);

        // 4: out_ready toggles 1,0,0,1; warp 3 waits behind warp 1
        do_reset();
        tog_en  = 1'b1;
        tog_idx = 0;
        load_seq(1, 40, STEPS_OK, 8'h00, -1, 8);
        load_seq(3, 41, STEPS_OK, 8'h00, -1, 8);
        wait_drain(200);
        tog_en = 1'b0;
        bus.out_ready = 1'b1;

        // 5: reset after the fifth fire, then a clean restart at beat 0
        do_reset();
        k = cyc;
        load_seq(1, 50, STEPS_OK, 8'h00, k + 1, 5);
        for (int n = 0; n < 30 && w_head[1] < 5; n++) step_clk();
        if (w_head[1] < 5) tmo_req++;
        #2;
        rst_n = 1'b0;
        for (int w = 0; w < NR; w++) w_head[w] = w_tail[w];
        drive();
        step_clk();
        step_clk();
        rst_n = 1'b1;
        k = cyc;
        load_seq(1, 51, STEPS_OK, 8'h00, k + 1, 8);
        wait_drain(60);

        // 6: all warps busy; grant order 0,1,2,3 then 0 again
        do_reset();
        k = cyc;
        load_seq(0, 60, STEPS_OK, 8'h00, k + 1, 8);
        load_seq(1, 61, STEPS_OK, 8'h00, k + 10, 8);
        load_seq(2, 62, STEPS_OK, 8'h00, k + 19, 8);
        load_seq(3, 63, STEPS_OK, 8'h00, k + 28, 8);
        load_seq(0, 64, STEPS_OK, 8'h00, k + 37, 8);
        wait_drain(120);

        step_clk();
        step_clk();
        step_clk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
